// File: rtl/move_arbiter.sv
// move_arbiter: drives one move-generation pass over NUM_SQ square FIFOs.
//
// A pass runs IDLE -> COLLECT -> SETTLE -> DRAIN -> DONE -> IDLE. During COLLECT,
// collect_pieces is broadcast for COLLECT_CYCLES cycles. SETTLE waits two cycles
// for in-flight FIFO writes to land. DRAIN then pops the square FIFOs round-robin
// into a single registered move output with a valid/ready handshake.
//
// Optional feature: define MOVE_ARBITER_COUNT_EN to add the move_count output, a
// saturating 10-bit count of accepted moves that clears when a pass starts.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          one-cycle pass request (honoured in IDLE only)
//   collect_pieces broadcast to all squares during COLLECT
//   stack_empty    per-square FIFO empty flags
//   stack_data     per-square show-ahead FIFO heads, square i at [16i+15:16i]
//   stack_read     one-hot FIFO pop pulse
//   move_valid     move_data/move_src hold a move
//   move_ready     downstream accepts the move
//   move_data      formatted move
//   move_src       index of the originating square
//   move_count     accepted-move count (MOVE_ARBITER_COUNT_EN only)
//   busy           pass in progress
//   done           one-cycle pass-complete pulse
module move_arbiter #(
  parameter int unsigned NUM_SQ         = 64,
  parameter int unsigned COLLECT_CYCLES = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      collect_pieces,
  input  logic [NUM_SQ-1:0]         stack_empty,
  input  logic [NUM_SQ*16-1:0]      stack_data,
  output logic [NUM_SQ-1:0]         stack_read,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic [15:0]               move_data,
  output logic [$clog2(NUM_SQ)-1:0] move_src,
`ifdef MOVE_ARBITER_COUNT_EN
  output logic [9:0]                move_count,
`endif
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned SrcW = $clog2(NUM_SQ);
  localparam int unsigned CntW = $clog2(COLLECT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StSettle,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SrcW-1:0]   ptr_q, ptr_d;
  logic [NUM_SQ-1:0] last_read_q;
  logic              quiet_q, quiet_d;
  logic              move_valid_q;
  logic [15:0]       move_data_q;
  logic [SrcW-1:0]   move_src_q;

  logic [15:0]       data_arr [NUM_SQ];
  logic [NUM_SQ-1:0] eligible;
  logic              can_load;
  logic              found;
  logic [SrcW-1:0]   grant_idx;
  logic              grant;
  logic              quiet_now;
  int unsigned       cand;

  for (genvar g = 0; g < NUM_SQ; g++) begin : g_unpack
    assign data_arr[g] = stack_data[g*16 +: 16];
  end

  // A square popped last cycle may still show its old empty flag; skip it once.
  assign eligible = ~stack_empty & ~last_read_q;
  assign can_load = !move_valid_q || move_ready;

  // Round-robin search starting at ptr_q.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_SQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_SQ) begin
        cand = cand - NUM_SQ;
      end
      if (!found && eligible[SrcW'(cand)]) begin
        found     = 1'b1;
        grant_idx = SrcW'(cand);
      end
    end
  end

  assign grant     = (state_q == StDrain) && can_load && found;
  assign quiet_now = (&stack_empty) && !grant;

  always_comb begin
    stack_read = '0;
    if (grant) begin
      stack_read[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && start) begin
      ptr_d = '0;
    end else if (grant) begin
      if (grant_idx == SrcW'(NUM_SQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SrcW'(1);
      end
    end
  end

  assign quiet_d = (state_q == StDrain) ? quiet_now : 1'b0;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    collect_pieces = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_q)
      StIdle: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        collect_pieces = 1'b1;
        if (cnt_q == CntW'(COLLECT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        // Two quiet cycles in a row with nothing left in the output register.
        if (quiet_now && quiet_q && !move_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      last_read_q <= '0;
      quiet_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      last_read_q <= stack_read;
      quiet_q     <= quiet_d;
    end
  end

  // Output register: a grant reloads it, an accept without a grant empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_valid_q <= 1'b0;
      move_data_q  <= '0;
      move_src_q   <= '0;
    end else if (grant) begin
      move_valid_q <= 1'b1;
      move_data_q  <= data_arr[grant_idx];
      move_src_q   <= grant_idx;
    end else if (move_ready) begin
      move_valid_q <= 1'b0;
    end
  end

  assign move_valid = move_valid_q;
  assign move_data  = move_data_q;
  assign move_src   = move_src_q;

`ifdef MOVE_ARBITER_COUNT_EN
  logic [9:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (state_q == StIdle && start) begin
      count_q <= '0;
    end else if (move_valid_q && move_ready && count_q != 10'd1023) begin
      count_q <= count_q + 10'd1;
    end
  end

  assign move_count = count_q;
`endif

endmodule

// File: tb/tb_move_arbiter.sv
module tb_move_arbiter;

  localparam int NSQ  = 64;
  localparam int COLL = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               move_ready = 1'b0;
  logic               collect_pieces;
  logic [NSQ-1:0]     stack_empty;
  logic [NSQ*16-1:0]  stack_data;
  logic [NSQ-1:0]     stack_read;
  logic               move_valid;
  logic [15:0]        move_data;
  logic [5:0]         move_src;
  logic               busy;
  logic               done;
`ifdef MOVE_ARBITER_COUNT_EN
  logic [9:0]         move_count;
`endif

  always #5 clk = ~clk;

  move_arbiter #(
    .NUM_SQ        (NSQ),
    .COLLECT_CYCLES(COLL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .collect_pieces(collect_pieces),
    .stack_empty   (stack_empty),
    .stack_data    (stack_data),
    .stack_read    (stack_read),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_data     (move_data),
    .move_src      (move_src),
`ifdef MOVE_ARBITER_COUNT_EN
    .move_count    (move_count),
`endif
    .busy          (busy),
    .done          (done)
  );

  // Show-ahead FIFO model per square; hd advances on stack_read, tl on push.
  logic [15:0] fmem [NSQ][16];
  int          hd [NSQ] = '{default: 0};
  int          tl [NSQ] = '{default: 0};

  always_comb begin
    stack_empty = '0;
    stack_data  = '0;
    for (int i = 0; i < NSQ; i++) begin
      stack_empty[i]         = (hd[i] == tl[i]);
      stack_data[i*16 +: 16] = fmem[i][hd[i] % 16];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NSQ; i++) begin
      if (stack_read[i]) hd[i] <= hd[i] + 1;
    end
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_collect = 0, n_read = 0, n_done = 0, n_multi = 0, n_consec = 0;
  int          n_rd_bad = 0, n_stall_rd = 0, n_unstable = 0;
  int          last_coll_cyc = 0, done_cyc = 0;
  int          rd_src [$];
  int          rd_cyc [$];
  int          acc_src [$];
  logic [15:0] acc_data [$];

  initial begin
    logic           prev_stall;
    logic [15:0]    prev_data;
    logic [5:0]     prev_src;
    logic [NSQ-1:0] prev_read;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_src   = '0;
    prev_read  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (collect_pieces) begin
          n_collect++;
          last_coll_cyc = cyc;
        end
        if (stack_read != '0) begin
          n_read++;
          if ($countones(stack_read) != 1) n_multi++;
          if ((stack_read & prev_read) != '0) n_consec++;
          if (!busy || collect_pieces) n_rd_bad++;
          if (move_valid && !move_ready) n_stall_rd++;
          for (int i = 0; i < NSQ; i++) begin
            if (stack_read[i]) rd_src.push_back(i);
          end
          rd_cyc.push_back(cyc);
        end
        if (prev_stall && (!move_valid || move_data != prev_data || move_src != prev_src))
          n_unstable++;
        if (move_valid && move_ready) begin
          acc_src.push_back(int'(move_src));
          acc_data.push_back(move_data);
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        prev_stall = move_valid && !move_ready;
        prev_data  = move_data;
        prev_src   = move_src;
        prev_read  = stack_read;
      end else begin
        prev_stall = 1'b0;
        prev_read  = '0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int sq, input logic [15:0] data);
    fmem[sq][tl[sq] % 16] = data;
    tl[sq]++;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k;
    k = 0;
    while (n_done == d0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, n_done - d0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!move_valid && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, move_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, d0, q0, a0, u0, s0, k0;
    int          exp_src [4];
    logic [15:0] exp_dat [4];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_collect", collect_pieces, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", move_valid, 0);
    check("rst_read", stack_read != '0, 0);
    check("rst_data", move_data, 0);
    check("rst_src", move_src, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", busy, 0);

    // Empty pass; a second start mid-COLLECT must be ignored.
    c0 = n_collect; r0 = n_read; d0 = n_done;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, "t1_done");
    check("t1_collect", n_collect - c0, COLL);
    check("t1_reads", n_read - r0, 0);
    check("t1_tail", done_cyc - last_coll_cyc, 5);
    check("t1_busy_low", busy, 0);

    // Squares 3 and 60, two moves each.
    push(3, 16'h0300); push(3, 16'h0301);
    push(60, 16'h3C00); push(60, 16'h3C01);
    move_ready = 1'b1;
    r0 = n_read; d0 = n_done; q0 = rd_src.size(); a0 = acc_src.size();
    pulse_start();
    wait_done(d0, "t2_done");
    check("t2_reads", n_read - r0, 4);
    exp_src = '{3, 60, 3, 60};
    exp_dat = '{16'h0300, 16'h3C00, 16'h0301, 16'h3C01};
    if (rd_src.size() < q0 + 4 || acc_src.size() < a0 + 4) begin
      check("t2_log_size", acc_src.size() - a0, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_rd_src%0d", i), rd_src[q0+i], exp_src[i]);
        check($sformatf("t2_acc_src%0d", i), acc_src[a0+i], exp_src[i]);
        check($sformatf("t2_acc_dat%0d", i), acc_data[a0+i], exp_dat[i]);
      end
      check("t2_first_gap", rd_cyc[q0] - last_coll_cyc, 3);
      check("t2_back2back", rd_cyc[q0+3] - rd_cyc[q0], 3);
      check("t2_done_gap", done_cyc - rd_cyc[q0+3], 3);
    end

    // Only square 5, three moves: never popped twice in a row.
    push(5, 16'h0500); push(5, 16'h0501); push(5, 16'h0502);
    r0 = n_read; d0 = n_done; a0 = acc_src.size(); k0 = n_consec;
    pulse_start();
    wait_done(d0, "t3_done");
    check("t3_consec", n_consec - k0, 0);
    check("t3_reads", n_read - r0, 3);
    check("t3_moves", acc_src.size() - a0, 3);
    if (acc_data.size() >= a0 + 3) begin
      check("t3_dat2", acc_data[a0+2], 16'h0502);
    end

    // Back-pressure: ready low for 10+ cycles with a move held.
    push(10, 16'h0A00); push(10, 16'h0A01);
    push(12, 16'h0C00); push(12, 16'h0C01);
    move_ready = 1'b0;
    d0 = n_done; a0 = acc_src.size(); s0 = n_stall_rd; u0 = n_unstable;
    pulse_start();
    wait_valid("t4_valid");
    repeat (10) @(posedge clk);
    #1;
    check("t4_hold_valid", move_valid, 1);
    check("t4_hold_data", move_data, 16'h0A00);
    check("t4_hold_src", move_src, 10);
    check("t4_stall_reads", n_stall_rd - s0, 0);
    check("t4_unstable", n_unstable - u0, 0);
    move_ready = 1'b1;
    wait_done(d0, "t4_done");
    exp_src = '{10, 12, 10, 12};
    exp_dat = '{16'h0A00, 16'h0C00, 16'h0A01, 16'h0C01};
    if (acc_src.size() < a0 + 4) begin
      check("t4_moves", acc_src.size() - a0, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t4_acc_src%0d", i), acc_src[a0+i], exp_src[i]);
        check($sformatf("t4_acc_dat%0d", i), acc_data[a0+i], exp_dat[i]);
      end
    end

    // Reset mid-DRAIN, then a fresh pass finishes the square.
    for (int i = 0; i < 6; i++) push(20, 16'h1400 + 16'(i));
    r0 = n_read;
    pulse_start();
    wait_valid("t5_valid");
    #2 rst = 1'b0;
    #1;
    check("t5_collect", collect_pieces, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_valid0", move_valid, 0);
    check("t5_read", stack_read != '0, 0);
    check("t5_data", move_data, 0);
    check("t5_src", move_src, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_idle_after_rst", busy, 0);
    c0 = n_collect; d0 = n_done;
    pulse_start();
    wait_done(d0, "t5_done2");
    check("t5_collect2", n_collect - c0, COLL);
    check("t5_reads_total", n_read - r0, 6);
    check("t5_sq_empty", stack_empty[20], 1);

`ifdef MOVE_ARBITER_COUNT_EN
    push(30, 16'h1E00); push(30, 16'h1E01); push(30, 16'h1E02);
    push(40, 16'h2800); push(40, 16'h2801);
    d0 = n_done;
    pulse_start();
    wait_done(d0, "t6_done");
    check("t6_count5", move_count, 5);
    d0 = n_done;
    pulse_start();
    check("t6_count_clr", move_count, 0);
    wait_done(d0, "t6_done2");
    check("t6_count_empty", move_count, 0);
`endif

    check("onehot", n_multi, 0);
    check("read_outside_drain", n_rd_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_arbiter.md
MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SQ, default 64, meaning number of square FIFOs served.
REQ-002 The block SHALL have parameter COLLECT_CYCLES, default 128, meaning cycles collect_pieces is held high per pass.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a generation pass.
REQ-006 The block SHALL have port collect_pieces  output  1  broadcast to all squares during COLLECT.
REQ-007 The block SHALL have port stack_empty  input  NUM_SQ  per-square FIFO empty flags.
REQ-008 The block SHALL have port stack_data  input  NUM_SQ*16  per-square show-ahead FIFO heads; square i occupies bits [16i+15:16i].
REQ-009 The block SHALL have port stack_read  output  NUM_SQ  one-hot pop pulses, at most one bit high per cycle.
REQ-010 The block SHALL have port move_valid  output  1  move_data/move_src hold a move.
REQ-011 The block SHALL have port move_ready  input  1  downstream accepts the move when high with move_valid.
REQ-012 The block SHALL have port move_data  output  16  formatted move.
REQ-013 The block SHALL have port move_src  output  $clog2(NUM_SQ)  index of the originating square.
REQ-014 The block SHALL have ports busy and done  output  1 each  pass in progress / one-cycle pass-complete pulse.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, SETTLE, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to COLLECT; start SHALL be ignored in all other states.
REQ-017 collect_pieces SHALL be high for exactly COLLECT_CYCLES cycles, starting the cycle after start is sampled.
REQ-018 After COLLECT the FSM SHALL spend exactly 2 cycles in SETTLE to absorb in-flight FIFO writes, then enter DRAIN.
REQ-019 In DRAIN a grant SHALL occur in any cycle where the output register is empty or is being accepted (move_valid and move_ready) and an eligible square exists.
REQ-020 Eligible square: stack_empty bit low, and not granted in the previous cycle (stale-empty guard).
REQ-021 Grants SHALL be round-robin: search starts at the index after the last grant and wraps NUM_SQ-1 to 0; the first search after reset or start begins at 0.
REQ-022 On a grant to square i, the block SHALL pulse stack_read[i] for one cycle and load move_data=stack_data[i], move_src=i, move_valid=1 at the next clock edge (zero bubble with concurrent accept).
REQ-023 move_valid SHALL stay high and move_data/move_src SHALL stay stable until accepted.
REQ-024 DRAIN SHALL exit to DONE once all stack_empty bits have been high for 2 consecutive cycles, no grant occurred in either cycle, and move_valid=0.
REQ-025 done SHALL pulse for one cycle in DONE, then the FSM SHALL return to IDLE.
REQ-026 busy SHALL be high in COLLECT, SETTLE, DRAIN and DONE, and low in IDLE.
REQ-027 No stack_read bit SHALL assert outside DRAIN.

Reset
REQ-028 rst low SHALL immediately force IDLE, with collect_pieces, stack_read, move_valid, busy and done all 0, move_data 0, move_src 0, RR pointer 0, and counters 0, including mid-pass.
REQ-029 After reset release, the first action SHALL require a new start.

Configuration
REQ-030 With MOVE_ARBITER_COUNT_EN defined, the block SHALL have an extra output move_count (10 bits) that clears on a start accepted in IDLE, increments on each move_valid&&move_ready, and saturates at 1023.
REQ-031 Without MOVE_ARBITER_COUNT_EN, the move_count port and its logic SHALL be absent, with otherwise identical behaviour.

Verification
REQ-032 start with all FIFOs empty -> collect_pieces high 128 cycles, 2 SETTLE cycles, no stack_read, done pulses, busy falls.
REQ-033 Squares 3 and 60 each hold 2 moves, move_ready=1 -> reads in order 3, 60, 3, 60, with move_src matching, one move per cycle, and done after the last one.
REQ-034 Only square 5 holds 3 moves -> stack_read[5] never asserts in two consecutive cycles, and exactly 3 moves are output.
REQ-035 move_ready held low for 10 cycles while move_valid=1 -> move_data stable, no stack_read during the stall, and no move lost.
REQ-036 rst asserted mid-DRAIN -> all outputs 0 asynchronously, and a subsequent start runs a full pass.
REQ-037 With MOVE_ARBITER_COUNT_EN defined and 5 moves drained -> move_count=5, and it clears to 0 on the next start.
